// File: rtl/parc_core_rob_scoreboard.sv
// Scoreboard sitting between decode and the reorder buffer.
// - Tracks which architectural registers still wait on an uncommitted producer.
// - Reserves the writeback slot each accepted instruction will complete in.
// - Requests ROB allocations and emits ROB fill notifications.
module parc_core_rob_scoreboard (
    input  logic       clk,
    input  logic       reset,

    input  logic       issue_val,
    output logic       issue_rdy,
    input  logic       issue_wen,
    input  logic [4:0] issue_waddr,
    input  logic       issue_ren0,
    input  logic [4:0] issue_raddr0,
    input  logic       issue_ren1,
    input  logic [4:0] issue_raddr1,
    input  logic [1:0] issue_lat,

    output logic       rob_alloc_req_val,
    input  logic       rob_alloc_req_rdy,
    output logic [4:0] rob_alloc_req_preg,
    input  logic [3:0] rob_alloc_resp_slot,

    output logic       rob_fill_val,
    output logic [3:0] rob_fill_slot,

    input  logic       rob_commit_wen,
    input  logic [3:0] rob_commit_slot,
    input  logic [4:0] rob_commit_rf_waddr
);

    typedef struct packed {
        logic       vld;
        logic [3:0] slot;
    } wb_t;

    logic [31:0]      pend;
    logic [31:0][3:0] pslot;
    wb_t  [3:0]       wb;

    logic raw;
    logic wbconf;
    logic fire;
    logic commit_hit;

    // Hazard checks and handshake. A commit in the same cycle is deliberately
    // not forwarded, so pend is read before any update this cycle.
    always_comb begin
        raw = (issue_ren0 && (issue_raddr0 != 5'd0) && pend[issue_raddr0]) ||
              (issue_ren1 && (issue_raddr1 != 5'd0) && pend[issue_raddr1]);
        // The new entry lands in wb[L-1] after the shift, which is where the
        // current wb[L] moves to. L=4 enters the empty top stage.
        wbconf = (issue_lat != 2'd3) && wb[issue_lat + 2'd1].vld;
        // Reset forces rdy low so nothing is allocated while state is cleared.
        issue_rdy = !reset && rob_alloc_req_rdy && !raw && !wbconf;
        fire = issue_val && issue_rdy;
        rob_alloc_req_val = fire;
        rob_alloc_req_preg = issue_wen ? issue_waddr : 5'd0;
        // Entries still in wb during a reset cycle belong to discarded issues.
        rob_fill_val = !reset && wb[0].vld;
        rob_fill_slot = wb[0].slot;
        commit_hit = rob_commit_wen && (rob_commit_rf_waddr != 5'd0) &&
                     pend[rob_commit_rf_waddr] &&
                     (pslot[rob_commit_rf_waddr] == rob_commit_slot);
    end

    // Writeback pipeline: shift toward stage 0 each cycle, then drop the newly
    // issued instruction into stage L-1 so it reaches stage 0 after L cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb <= '0;
        end else begin
            for (int i = 0; i < 3; i++) wb[i] <= wb[i+1];
            wb[3] <= '0;
            if (fire) wb[issue_lat] <= '{vld: 1'b1, slot: rob_alloc_resp_slot};
        end
    end

    // Pending-register table. Commit clears only when the committing slot is
    // the youngest producer; a later issue to the same register overrides it.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend  <= '0;
            pslot <= '0;
        end else begin
            if (commit_hit) pend[rob_commit_rf_waddr] <= 1'b0;
            if (fire && issue_wen && (issue_waddr != 5'd0)) begin
                pend[issue_waddr]  <= 1'b1;
                pslot[issue_waddr] <= rob_alloc_resp_slot;
            end
        end
    end

endmodule
